// File: rtl/keypad_scan_controller_if.sv
// Pin-side and event-side signals of the matrix keypad scanner.
// The scanner takes the slave view; whatever models the keypad takes the master view.
interface keypad_scan_controller_if #(
    parameter int NUM_ROWS = 4,
    parameter int NUM_COLS = 4,
    parameter int CODE_W   = $clog2(NUM_ROWS * NUM_COLS)
);
    logic [NUM_ROWS-1:0] rows_async;
    logic [NUM_COLS-1:0] cols;
    logic [CODE_W-1:0]   key_code;
    logic                key_valid;
    logic                key_held;

    modport master (output rows_async, input cols, key_code, key_valid, key_held);
    modport slave  (input rows_async, output cols, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scan_controller.sv
// Matrix keypad scanner: walks a one-cold column drive, synchronises the row pins,
// debounces press and release of a single key and reports it as pulse plus level.
module keypad_scan_controller #(
    parameter int NUM_ROWS        = 4,
    parameter int NUM_COLS        = 4,
    parameter int SCAN_DWELL      = 64,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CODE_W          = $clog2(NUM_ROWS * NUM_COLS)
) (
    input  logic                    clk,
    input  logic                    reset,
    keypad_scan_controller_if.slave kp
);
    localparam int CNT_MAX = (SCAN_DWELL > DEBOUNCE_CYCLES) ? SCAN_DWELL : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int COL_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DWELL - 1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(NUM_COLS - 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [COL_W-1:0]    col_r, col_s;
    logic [ROW_W-1:0]    row_r, row_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [NUM_ROWS-1:0] rows_meta_r, rows_sync_r;
    logic [NUM_COLS-1:0] cols_r, cols_s;
    logic [CODE_W-1:0]   key_code_r, key_code_s;
    logic                key_valid_r, key_valid_s;
    logic                key_held_r, key_held_s;

    function automatic logic [NUM_COLS-1:0] col_drive(input logic [COL_W-1:0] idx);
        logic [NUM_COLS-1:0] one_hot;
        one_hot      = {NUM_COLS{1'b0}};
        one_hot[idx] = 1'b1;
        return ~one_hot;
    endfunction

    // Rows are active-low; scanning downwards leaves the lowest low index as the winner.
    function automatic logic [ROW_W-1:0] lowest_low(input logic [NUM_ROWS-1:0] rows);
        logic [ROW_W-1:0] idx;
        idx = {ROW_W{1'b0}};
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = ROW_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [COL_W-1:0] next_col(input logic [COL_W-1:0] idx);
        return (idx == COL_LAST) ? {COL_W{1'b0}} : idx + COL_W'(1);
    endfunction

    // Two-flop synchroniser for the asynchronous row pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rows_meta_r <= {NUM_ROWS{1'b0}};
            rows_sync_r <= {NUM_ROWS{1'b0}};
        end else begin
            rows_meta_r <= kp.rows_async;
            rows_sync_r <= rows_meta_r;
        end
    end

    // Scan / debounce / hold decisions and next values of every registered output.
    always_comb begin
        state_s     = state_r;
        col_s       = col_r;
        row_s       = row_r;
        cnt_s       = cnt_r;
        key_code_s  = key_code_r;
        key_valid_s = 1'b0;
        key_held_s  = key_held_r;
        case (state_r)
            ST_SCAN: begin
                if (cnt_r == DWELL_LAST) begin
                    cnt_s = {CNT_W{1'b0}};
                    if (rows_sync_r != {NUM_ROWS{1'b1}}) begin
                        row_s   = lowest_low(rows_sync_r);
                        state_s = ST_DEBOUNCE;
                    end else begin
                        col_s = next_col(col_r);
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (rows_sync_r[row_r]) begin
                    state_s = ST_SCAN;
                    col_s   = next_col(col_r);
                    cnt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == DEB_LAST) begin
                    state_s     = ST_PRESSED;
                    cnt_s       = {CNT_W{1'b0}};
                    key_code_s  = CODE_W'(row_r) * CODE_W'(NUM_COLS) + CODE_W'(col_r);
                    key_valid_s = 1'b1;
                    key_held_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                // Any low sample is a bounce and restarts the release count.
                if (!rows_sync_r[row_r]) begin
                    cnt_s = {CNT_W{1'b0}};
                end else if (cnt_r == DEB_LAST) begin
                    state_s    = ST_SCAN;
                    col_s      = next_col(col_r);
                    cnt_s      = {CNT_W{1'b0}};
                    key_held_s = 1'b0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s    = ST_SCAN;
                col_s      = {COL_W{1'b0}};
                cnt_s      = {CNT_W{1'b0}};
                key_held_s = 1'b0;
            end
        endcase
        cols_s = col_drive(col_s);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_SCAN;
            col_r       <= {COL_W{1'b0}};
            row_r       <= {ROW_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            cols_r      <= col_drive({COL_W{1'b0}});
            key_code_r  <= {CODE_W{1'b0}};
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            col_r       <= col_s;
            row_r       <= row_s;
            cnt_r       <= cnt_s;
            cols_r      <= cols_s;
            key_code_r  <= key_code_s;
            key_valid_r <= key_valid_s;
            key_held_r  <= key_held_s;
        end
    end

    assign kp.cols      = cols_r;
    assign kp.key_code  = key_code_r;
    assign kp.key_valid = key_valid_r;
    assign kp.key_held  = key_held_r;
endmodule

// File: tb/tb_keypad_scan_controller.sv
// Directed bench for keypad_scan_controller with a physical key-matrix model and a
// scoreboard that pairs every key_valid pulse with an expected key code.
module tb_keypad_scan_controller;
    logic clk   = 1'b0;
    logic reset = 1'b0;

    keypad_scan_controller_if #(.NUM_ROWS(4), .NUM_COLS(4), .CODE_W(4)) kp ();

    keypad_scan_controller #(
        .NUM_ROWS(4), .NUM_COLS(4), .SCAN_DWELL(4), .DEBOUNCE_CYCLES(8), .CODE_W(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .kp   (kp)
    );

    always #5 clk = ~clk;

    // Closed switches, index row*4+col; a row reads low only while its column is driven low.
    logic [15:0] pressed = 16'h0000;
    logic [3:0]  rows_model;
    always_comb begin
        rows_model = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !kp.cols[c]) rows_model[r] = 1'b0;
            end
        end
    end
    assign kp.rows_async = rows_model;

    int checks      = 0;
    int failures    = 0;
    int pulse_count = 0;
    logic [3:0] exp_q[$];

    // Scoreboard monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (kp.key_valid === 1'b1) begin
            pulse_count++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse actual_code=%0d required=no_pulse", kp.key_code);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (kp.key_code !== e) begin
                    failures++;
                    $display("FAIL pulse_code actual=%0d required=%0d", kp.key_code, e);
                end
            end
            checks++;
            if (kp.key_held !== 1'b1) begin
                failures++;
                $display("FAIL held_at_pulse actual=%b required=1", kp.key_held);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_cols(input logic [3:0] v, input int budget, input string name);
        for (int i = 0; i < budget && kp.cols !== v; i++) cyc(1);
        check(name, 32'(kp.cols), 32'(v));
    endtask

    task automatic wait_pulses(input int target, input int budget, input string name);
        for (int i = 0; i < budget && pulse_count < target; i++) cyc(1);
        check(name, 32'(pulse_count), 32'(target));
    endtask

    task automatic wait_held(input logic v, input int budget, input string name);
        for (int i = 0; i < budget && kp.key_held !== v; i++) cyc(1);
        check(name, 32'(kp.key_held), 32'(v));
    endtask

    logic [3:0] scan_seq [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    int pc;

    initial begin
        cyc(3);
        check("reset_cols", 32'(kp.cols), 32'h0000000e);
        check("reset_valid", 32'(kp.key_valid), 32'h0);
        check("reset_held", 32'(kp.key_held), 32'h0);
        check("reset_code", 32'(kp.key_code), 32'h0);

        // Idle scan: one column step every 4 cycles with wrap.
        reset = 1'b1;
        check("scan_col_0", 32'(kp.cols), 32'(scan_seq[0]));
        for (int k = 1; k < 5; k++) begin
            cyc(4);
            check($sformatf("scan_col_%0d", k), 32'(kp.cols), 32'(scan_seq[k]));
            check($sformatf("scan_held_%0d", k), 32'(kp.key_held), 32'h0);
        end

        // Row 2 / column 1 pressed once its column is driven.
        wait_cols(4'b1101, 20, "reach_col1");
        pressed[9] = 1'b1;
        exp_q.push_back(4'd9);
        wait_pulses(1, 40, "press_r2c1_pulse");
        check("held_after_press", 32'(kp.key_held), 32'h1);
        cyc(5);
        check("held_steady", 32'(kp.key_held), 32'h1);
        check("col_locked", 32'(kp.cols), 32'h0000000d);

        // Release with three short re-bounces; held falls 8 stable cycles after the last.
        for (int b = 0; b < 3; b++) begin
            pressed[9] = 1'b0;
            cyc(3);
            pressed[9] = 1'b1;
            cyc(1);
        end
        pressed[9] = 1'b0;
        cyc(9);
        check("held_before_release", 32'(kp.key_held), 32'h1);
        cyc(1);
        check("held_released", 32'(kp.key_held), 32'h0);
        check("resume_col2", 32'(kp.cols), 32'h0000000b);
        check("code_kept", 32'(kp.key_code), 32'h9);

        // Bouncing contact (period 6) for 40 cycles, then stable closed.
        pc = pulse_count;
        exp_q.push_back(4'd9);
        for (int i = 0; i < 40; i++) begin
            pressed[9] = ((i / 3) % 2 == 0);
            cyc(1);
        end
        check("bounce_no_pulse", 32'(pulse_count), 32'(pc));
        pressed[9] = 1'b1;
        wait_pulses(pc + 1, 60, "bounce_then_stable_pulse");
        pressed[9] = 1'b0;
        wait_held(1'b0, 40, "bounce_release");

        // Rows 1 and 3 low on column 0: the lower row wins.
        pc = pulse_count;
        pressed[4]  = 1'b1;
        pressed[12] = 1'b1;
        exp_q.push_back(4'd4);
        wait_pulses(pc + 1, 60, "multi_row_pulse");
        check("multi_row_code", 32'(kp.key_code), 32'h4);
        pressed = 16'h0000;
        wait_held(1'b0, 40, "multi_row_release");

        // Reset asserted mid-debounce discards the key.
        wait_cols(4'b1110, 20, "reach_col0");
        pressed[9] = 1'b1;
        wait_cols(4'b1101, 20, "reach_col1_again");
        pc = pulse_count;
        cyc(6);
        reset = 1'b0;
        #1;
        check("async_rst_valid", 32'(kp.key_valid), 32'h0);
        check("async_rst_held", 32'(kp.key_held), 32'h0);
        check("async_rst_code", 32'(kp.key_code), 32'h0);
        check("async_rst_cols", 32'(kp.cols), 32'h0000000e);
        pressed = 16'h0000;
        cyc(2);
        reset = 1'b1;
        check("post_rst_cols", 32'(kp.cols), 32'h0000000e);
        cyc(30);
        check("post_rst_no_pulse", 32'(pulse_count), 32'(pc));
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
